// File: rtl/id_ex_control_stage.sv
// ID-stage main control decoder plus the ID/EX control pipeline register.
// Detects load-use hazards, stalls IF/ID, and inserts bubbles on hazard or flush.
module id_ex_control_stage #(
    parameter int unsigned HAZARD_EN = 1,
    parameter int unsigned REG_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             flush,
    output logic             stall_if_id,
    output logic             ex_valid,
    output logic [1:0]       ex_alu_op,
    output logic [3:0]       ex_function,
    output logic             ex_alu_src,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_reg_write,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic [REG_W-1:0] ex_write_reg,
    output logic [REG_W-1:0] ex_rs,
    output logic [REG_W-1:0] ex_rt,
    output logic             illegal_seen
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    typedef struct packed {
        logic             valid;
        logic [1:0]       alu_op;
        logic [3:0]       func;
        logic             alu_src;
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
        logic             reg_write;
        logic             branch;
        logic             jump;
        logic [REG_W-1:0] write_reg;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
    } ctrl_t;

    logic [5:0]       id_op;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    logic [3:0]       id_func;
    logic             unused_instr_bits;

    assign id_op   = id_instr[31:26];
    assign id_rs   = id_instr[25:21];
    assign id_rt   = id_instr[20:16];
    assign id_rd   = id_instr[15:11];
    assign id_func = id_instr[3:0];
    assign unused_instr_bits = ^id_instr[10:4];

    ctrl_t dec;
    logic  dec_legal;
    logic  dec_uses_rt;

    always_comb begin
        dec         = '0;
        dec_legal   = 1'b1;
        dec_uses_rt = 1'b0;
        case (id_op)
            OpRtype: begin
                dec.alu_op    = 2'b00;
                dec.func      = id_func;
                dec.reg_write = 1'b1;
                dec.write_reg = id_rd;
                dec_uses_rt   = 1'b1;
            end
            OpLw: begin
                dec.alu_op     = 2'b11;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.write_reg  = id_rt;
            end
            OpSw: begin
                dec.alu_op    = 2'b11;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec_uses_rt   = 1'b1;
            end
            OpAddi: begin
                dec.alu_op    = 2'b11;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.write_reg = id_rt;
            end
            OpSlti: begin
                dec.alu_op    = 2'b10;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.write_reg = id_rt;
            end
            OpBeq: begin
                dec.alu_op  = 2'b01;
                dec.branch  = 1'b1;
                dec_uses_rt = 1'b1;
            end
            OpJ: begin
                dec.alu_op = 2'b00;
                dec.jump   = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
        dec.valid = 1'b1;
        dec.rs    = id_rs;
        dec.rt    = id_rt;
        // r0 is hard-wired zero; everything else about the instruction still loads.
        if (dec.write_reg == '0) begin
            dec.reg_write = 1'b0;
        end
        if (!dec_legal) begin
            dec = '0;
        end
    end

    ctrl_t ex_q, ex_d;
    logic  illegal_q, illegal_d;
    logic  hazard;

    // Only a load in EX with a non-zero destination can create a load-use hazard.
    assign hazard = (HAZARD_EN != 0) && id_valid && ex_q.valid && ex_q.mem_read &&
                    (ex_q.rt != '0) &&
                    ((ex_q.rt == id_rs) || ((ex_q.rt == id_rt) && dec_uses_rt));

    assign stall_if_id = hazard && !flush;

    always_comb begin
        ex_d      = ex_q;
        illegal_d = illegal_q;
        if (flush || hazard || !id_valid) begin
            ex_d = '0;
        end else begin
            ex_d = dec;
            if (!dec_legal) begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_function   = ex_q.func;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_branch     = ex_q.branch;
    assign ex_jump       = ex_q.jump;
    assign ex_write_reg  = ex_q.write_reg;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign illegal_seen  = illegal_q;

endmodule

// File: doc/id_ex_control_stage.md
Name: id_ex_control_stage

Overview:
- Main control decoder for the ID stage, plus the ID/EX control pipeline register.
- Produces the 2-bit ALUOp and the 4-bit function code consumed by the EX-stage ALU control. It is the producing end of that interface.
- Detects load-use hazards, stalls IF/ID, inserts bubbles, and honours branch flushes.
- Sits between the IF/ID register and the EX stage.

Parameters:
- HAZARD_EN, 1, 1 = load-use detection active; 0 = stall_if_id tied 0, no hazard bubbles.
- REG_W, 5, register-address width; fixed at 5, not overridable in practice.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  IF/ID register holds a real instruction
- id_instr  in  32  fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], function[3:0]
- flush  in  1  branch/jump taken in EX; squash the ID instruction
- stall_if_id  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX stage holds a real instruction
- ex_alu_op  out  2  ALUOp to EX-stage ALU control
- ex_function  out  4  function code to EX-stage ALU control
- ex_alu_src  out  1  ALU B operand = sign-extended immediate
- ex_mem_read  out  1  load
- ex_mem_write  out  1  store
- ex_mem_to_reg  out  1  writeback from memory
- ex_reg_write  out  1  register-file write enable
- ex_branch  out  1  beq
- ex_jump  out  1  j
- ex_write_reg  out  5  destination register
- ex_rs  out  5  registered rs
- ex_rt  out  5  registered rt
- illegal_seen  out  1  sticky flag: undefined opcode decoded

Behaviour:
- Decode table. Signals not listed are 0.
  - 000000 R-type: alu_op=00, function=instr[3:0], reg_write=1, write_reg=rd; uses rt.
  - 100011 lw: alu_op=11, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, write_reg=rt.
  - 101011 sw: alu_op=11, alu_src=1, mem_write=1; uses rt.
  - 001000 addi: alu_op=11, alu_src=1, reg_write=1, write_reg=rt.
  - 001010 slti: alu_op=10, alu_src=1, reg_write=1, write_reg=rt.
  - 000100 beq: alu_op=01, branch=1; uses rt.
  - 000010 j: jump=1, alu_op=00.
- Non-R-type instructions: ex_function=0000.
- Any other opcode is illegal: it loads as a bubble and sets illegal_seen.
- Writes to r0 force reg_write=0. All other fields still load.
- Bubble: ex_valid and every control output 0; ex_write_reg, ex_rs, ex_rt, ex_function all 0.
- hazard (combinational): HAZARD_EN & id_valid & ex_valid & ex_mem_read & ex_rt!=0, and either
  - ex_rt==rs, or
  - ex_rt==rt while the ID instruction uses rt.
- stall_if_id = hazard & ~flush.
- Register update on each rising clk, priority order:
  1. rst_n==0: all ex_* outputs and illegal_seen go to 0.
  2. flush: load a bubble. No illegal flag, no stall.
  3. hazard: load a bubble. The ID instruction is retained upstream and re-decoded next cycle.
  4. otherwise: load the decoded instruction, or a bubble if id_valid==0.
- Latency: ID to EX is exactly 1 cycle. A load-use pair costs exactly 1 bubble.
- A stall never persists longer than 1 cycle: the bubble clears ex_mem_read, so the next cycle proceeds.
- illegal_seen:
  - Sets on the cycle an illegal opcode loads with id_valid=1 and no flush.
  - Stays set until reset.
  - Not set when the illegal instruction is squashed by flush.
- Reset mid-stall: stall drops the cycle after reset because ex_valid=0. No residual state.
- Simultaneous flush and hazard: flush wins, stall_if_id=0.

Test Plan:
1. Reset then a sequence of R-type (function 0101) and lw/sw/addi/slti/beq/j, no hazards. Required: each ex_* field matches the decode table 1 cycle later. ex_alu_op sequence is 00, 11, 11, 11, 10, 01, 00; ex_function is 0101 for the R-type, 0000 otherwise.
2. lw r3,0(r1) followed by add r4,r3,r2. Required: stall_if_id=1 for exactly 1 cycle, one bubble (ex_valid=0), then the add loads with ex_rs=3.
3. lw r3 followed by addi r5,r3,1 (rs match), then by addi r3,r0,1 (rt is a destination, not a source). Required: stall on the first case, no stall on the second. Also lw r0 followed by an r0 consumer: no stall.
4. Load-use hazard with flush=1 in the same cycle. Required: stall_if_id=0 and a bubble loaded. With HAZARD_EN=0, the case from scenario 2 gives stall_if_id=0.
5. Opcode 111111 with id_valid=1. Required: bubble loaded, illegal_seen=1 and it persists. The same opcode under flush leaves illegal_seen=0. rst_n=0 for one cycle clears it.
6. add r0,r1,r2 gives ex_reg_write=0 and ex_valid=1. Asserting rst_n=0 during a stall cycle gives all outputs 0 on the next edge and stall_if_id=0 after it.
